// File: rtl/vend_ctrl_param_if.sv
// Signal bundle between the vending controller and its surroundings
// (coin decoder, buttons, display and alarm drivers).
interface vend_ctrl_param_if #(
    parameter int N_PROD  = 4,
    parameter int AMT_W   = 8,
    parameter int SALES_W = 16
);
    localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    // Handshake: coin_valid, select_valid, cancel, restock_valid and clear_sales are one-cycle
    // strobes sampled on the rising clock edge with no ready/back-pressure; payloads matter only
    // while their strobe is high. dispense, change_valid and alarm are one-cycle output pulses
    // whose payloads (dispense_code, change_amt, alarm_code) hold between pulses.
    logic               coin_valid;
    logic [AMT_W-1:0]   coin_value;
    logic               select_valid;
    logic [SEL_W-1:0]   select_code;
    logic               cancel;
    logic               restock_valid;
    logic               clear_sales;

    logic [AMT_W-1:0]   credit;
    logic               dispense;
    logic [SEL_W-1:0]   dispense_code;
    logic               change_valid;
    logic [AMT_W-1:0]   change_amt;
    logic               alarm;
    logic [1:0]         alarm_code;
    logic [SALES_W-1:0] sales_total;
    logic [1:0]         state;

    modport master (
        output coin_valid, coin_value, select_valid, select_code, cancel, restock_valid, clear_sales,
        input  credit, dispense, dispense_code, change_valid, change_amt, alarm, alarm_code,
               sales_total, state
    );

    modport slave (
        input  coin_valid, coin_value, select_valid, select_code, cancel, restock_valid, clear_sales,
        output credit, dispense, dispense_code, change_valid, change_amt, alarm, alarm_code,
               sales_total, state
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, per-product price/stock table,
// dispense and change pulses, saturating sales total.
module vend_ctrl_param #(
    parameter int N_PROD     = 4,
    parameter int AMT_W      = 8,
    parameter int SALES_W    = 16,
    parameter int STOCK_W    = 4,
    parameter int STOCK_MAX  = 9,
    parameter int MAX_CREDIT = 99,
    parameter int TIMEOUT    = 30,
    parameter logic [N_PROD*AMT_W-1:0] PRICE_TABLE = {8'd20, 8'd15, 8'd10, 8'd5}
) (
    input logic              clk_1Hz,
    input logic              rst_n,
    vend_ctrl_param_if.slave bus
);
    localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CREDIT = 2'b01,
        S_VEND   = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   credit_q, credit_d;
    logic               disp_q, disp_d;
    logic [SEL_W-1:0]   disp_code_q, disp_code_d;
    logic               chg_v_q, chg_v_d;
    logic [AMT_W-1:0]   chg_amt_q, chg_amt_d;
    logic               alarm_q, alarm_d;
    logic [1:0]         alarm_code_q, alarm_code_d;
    logic [SALES_W-1:0] sales_q, sales_d, sales_base;
    logic [SALES_W:0]   sales_sum;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [STOCK_W-1:0] stock_q [N_PROD];

    logic [AMT_W-1:0]   sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               code_ok;
    logic [AMT_W:0]     coin_sum;
    logic               coin_ok;
    logic               sale;
    logic               restock;

    always_comb begin
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.select_code == SEL_W'(i)) begin
                sel_price = PRICE_TABLE[i*AMT_W +: AMT_W];
                sel_stock = stock_q[i];
            end
        end
    end

    assign code_ok  = int'(bus.select_code) < N_PROD;
    // Sum one bit wider so an overflowing coin is still seen as exceeding the ceiling.
    assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_ok  = coin_sum <= (AMT_W+1)'(MAX_CREDIT);

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        disp_d       = 1'b0;
        disp_code_d  = disp_code_q;
        chg_v_d      = 1'b0;
        chg_amt_d    = chg_amt_q;
        alarm_d      = 1'b0;
        alarm_code_d = alarm_code_q;
        timer_d      = timer_q;
        sale         = 1'b0;
        restock      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = bus.coin_value;
                        timer_d  = '0;
                        state_d  = S_CREDIT;
                    end else begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b11;
                    end
                end
                restock = bus.restock_valid && code_ok;
            end
            S_CREDIT: begin
                // The timer holds the count of eventless cycles already spent here.
                if (bus.cancel || timer_q == TMR_W'(TIMEOUT - 1)) begin
                    chg_amt_d = credit_q;
                    chg_v_d   = 1'b1;
                    credit_d  = '0;
                    state_d   = S_IDLE;
                    if (bus.coin_valid) begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b11;
                    end
                end else if (bus.select_valid) begin
                    timer_d = '0;
                    if (!code_ok || sel_stock == '0) begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b10;
                    end else if (credit_q < sel_price) begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b01;
                    end else begin
                        sale        = 1'b1;
                        disp_d      = 1'b1;
                        disp_code_d = bus.select_code;
                        credit_d    = credit_q - sel_price;
                        state_d     = S_VEND;
                    end
                    if (bus.coin_valid && !alarm_d) begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b11;
                    end
                end else if (bus.coin_valid) begin
                    timer_d = '0;
                    if (coin_ok) begin
                        credit_d = coin_sum[AMT_W-1:0];
                    end else begin
                        alarm_d      = 1'b1;
                        alarm_code_d = 2'b11;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_VEND: begin
                chg_amt_d = credit_q;
                chg_v_d   = (credit_q != '0);
                credit_d  = '0;
                state_d   = S_IDLE;
                if (bus.coin_valid) begin
                    alarm_d      = 1'b1;
                    alarm_code_d = 2'b11;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear is applied before the sale's add, so a coinciding sale leaves exactly its price.
        sales_base = bus.clear_sales ? '0 : sales_q;
        sales_sum  = {1'b0, sales_base} + (SALES_W+1)'(sel_price);
        sales_d    = sales_base;
        if (sale) begin
            sales_d = sales_sum[SALES_W] ? '1 : sales_sum[SALES_W-1:0];
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            disp_q       <= 1'b0;
            disp_code_q  <= '0;
            chg_v_q      <= 1'b0;
            chg_amt_q    <= '0;
            alarm_q      <= 1'b0;
            alarm_code_q <= '0;
            sales_q      <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            disp_q       <= disp_d;
            disp_code_q  <= disp_code_d;
            chg_v_q      <= chg_v_d;
            chg_amt_q    <= chg_amt_d;
            alarm_q      <= alarm_d;
            alarm_code_q <= alarm_code_d;
            sales_q      <= sales_d;
            timer_q      <= timer_d;
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_MAX);
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (sale && bus.select_code == SEL_W'(i)) begin
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
                end else if (restock && bus.select_code == SEL_W'(i)) begin
                    stock_q[i] <= STOCK_W'(STOCK_MAX);
                end
            end
        end
    end

    assign bus.credit        = credit_q;
    assign bus.dispense      = disp_q;
    assign bus.dispense_code = disp_code_q;
    assign bus.change_valid  = chg_v_q;
    assign bus.change_amt    = chg_amt_q;
    assign bus.alarm         = alarm_q;
    assign bus.alarm_code    = alarm_code_q;
    assign bus.sales_total   = sales_q;
    assign bus.state         = state_q;
endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller for the 1 Hz domain: accumulates coin credit, checks a product selection against a per-product price table and stock counters, issues dispense and change pulses, and keeps a saturating sales total. It replaces the fixed single-product controller. Upstream sits the coin-code decoder (already producing `coin_value`) and debounced buttons. Downstream sit the display and alarm drivers.

## Interface
- `N_PROD`, default 4: number of products; `SEL_W = max(1, clog2(N_PROD))` is a local parameter.
- `AMT_W`, default 8: credit, price and change width.
- `SALES_W`, default 16: sales accumulator width.
- `STOCK_W`, default 4: per-product stock counter width.
- `STOCK_MAX`, default 9: stock value loaded at reset and on restock.
- `MAX_CREDIT`, default 99: credit ceiling.
- `TIMEOUT`, default 30: idle cycles in CREDIT before an automatic refund.
- `PRICE_TABLE`, default {8'd20,8'd15,8'd10,8'd5}: flat N_PROD*AMT_W vector; product i price is `PRICE_TABLE[i*AMT_W +: AMT_W]`.
- `clk_1Hz` in 1: clock. The reset is `rst_n` (asynchronous, active-low) and the clock is `clk_1Hz`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `coin_valid` in 1: one-cycle coin-insert strobe.
- `coin_value` in AMT_W: value of the inserted coin.
- `select_valid` in 1: one-cycle confirm strobe.
- `select_code` in SEL_W: selected product.
- `cancel` in 1: one-cycle refund request.
- `restock_valid` in 1: one-cycle restock strobe; reloads stock of `select_code` with STOCK_MAX.
- `clear_sales` in 1: zeroes the sales total.
- `credit` out AMT_W: current credit.
- `dispense` out 1: one-cycle dispense pulse.
- `dispense_code` out SEL_W: product dispensed; holds its value between pulses.
- `change_valid` out 1: one-cycle change pulse.
- `change_amt` out AMT_W: change or refund amount; holds until the next pulse.
- `alarm` out 1: one-cycle alarm pulse.
- `alarm_code` out 2: 01 = insufficient credit, 10 = sold out or invalid code, 11 = coin rejected; holds its value between pulses.
- `sales_total` out SALES_W: saturating accumulated sales.
- `state` out 2: 00 = IDLE, 01 = CREDIT, 10 = VEND.

## Operation
- **Reset:** all outputs 0, `state` = IDLE, every stock counter = STOCK_MAX.
- **IDLE:**
  - `coin_valid`: credit ← min(coin_value, MAX_CREDIT rule below); go to CREDIT.
  - `select_valid` or `cancel`: ignored.
  - `restock_valid`: honoured only in IDLE, and only if `select_code` < N_PROD.
- **CREDIT:** events are evaluated in priority order cancel > timeout > select > coin.
  - `cancel`, or the timer reaching TIMEOUT: change_amt ← credit, change_valid ← 1, credit ← 0, go to IDLE.
  - `select_valid` with code ≥ N_PROD or stock = 0: alarm, code 10; stay in CREDIT.
  - `select_valid` with credit < price: alarm, code 01; stay in CREDIT.
  - Otherwise accept the selection:
    - dispense ← 1, dispense_code ← code.
    - credit ← credit − price, stock[code] −1.
    - sales_total ← sales_total + price, saturating at all-ones.
    - Go to VEND.
  - `coin_valid` accepted (no higher-priority event): credit ← credit + coin_value.
  - If credit + coin_value > MAX_CREDIT, the coin is rejected: credit unchanged, alarm, code 11.
  - A coin arriving in the same cycle as cancel, timeout or select is rejected with code 11. If a select alarm fires in that cycle, the select alarm code wins and only one alarm pulse is produced.
  - Timer: cleared on entry to CREDIT and on every coin, select or cancel event; otherwise increments by 1 per cycle.
- **VEND:** exactly one cycle.
  - dispense ← 0, change_amt ← credit, change_valid ← (credit ≠ 0), credit ← 0; go to IDLE.
  - Coins in VEND are rejected with code 11; select and cancel are ignored.
- **Sales total:**
  - `clear_sales` is honoured in any state.
  - If it coincides with a sale, the result is sales_total = price (clear is applied first, then the add).
- **Arithmetic:**
  - The credit sum is computed AMT_W+1 bits wide before comparison with MAX_CREDIT.
  - The sales add is zero-extended and saturating.

## Timing
- All outputs are registered and update on the posedge of `clk_1Hz`.
- Select accepted at edge k: `dispense` is high from k to k+1. At edge k+1, `change_valid` rises and stays high for one cycle.
- Cancel or timeout at edge k: `change_valid` is high from k to k+1.
- Timeout fires on the TIMEOUT-th consecutive cycle without an event.
- Asserting `rst_n` mid-vend aborts the vend: credit is lost, no change is pulsed, and stock and sales are returned to their reset values.

## Test plan
- Reset, coin 10, coin 10, select 2 (price 15): dispense one cycle later, dispense_code = 2, change_amt = 5 with change_valid one cycle after dispense, sales_total = 15, stock[2] = 8.
- Coin 5, select 3 (price 20): alarm, alarm_code 01, credit stays 5. Cancel: change_amt = 5, credit = 0, state = IDLE.
- Credit 95, coin 10: rejected, alarm_code 11, credit stays 95. Then 30 idle cycles: refund of 95.
- Drain product 0 with 9 sales, then select 0 with sufficient credit: alarm_code 10. Restock in IDLE: stock[0] = 9, next purchase succeeds.
- Select and coin in the same cycle with sufficient credit: dispense occurs, coin rejected (alarm_code 11). clear_sales in the same cycle as a price-10 sale: sales_total = 10.
- Preload sales_total near all-ones (SALES_W = 8 variant): sale saturates at 255. `rst_n` low while in VEND: all outputs 0 at once.
